// File: rtl/qlearn_step_ctrl.sv
// Per-step sequencing control for the Q-learning accelerator. It owns the agent state,
// the explore/exploit decision, the Q-table write strobe, episode bookkeeping and epsilon decay.
module qlearn_step_ctrl #(
    parameter logic [7:0]  GOAL_STATE   = 8'd99,
    parameter logic [7:0]  MAX_STEPS    = 8'd200,
    parameter logic [15:0] MAX_EPISODES = 16'd1000,
    parameter logic [9:0]  EPS_INIT     = 10'd512,
    parameter logic [9:0]  EPS_STEP     = 10'd16,
    parameter logic [7:0]  EPS_DECAY_EP = 8'd16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [9:0]  rand_val,
    input  logic [1:0]  nxt_act_in,
    input  logic [7:0]  nxt_state_in,
    output logic [7:0]  curr_state,
    output logic [7:0]  prev_state,
    output logic [1:0]  act_q,
    output logic        act_sel,
    output logic        q_wr_en,
    output logic        state_rst,
    output logic [9:0]  epsilon,
    output logic [7:0]  step_cnt,
    output logic [15:0] episode_cnt,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECIDE, S_MOVE, S_WRITE, S_ADVANCE, S_EPEND, S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  curr_q, curr_d, prev_q, prev_d, nxt_q, nxt_d;
    logic [1:0]  act_lat_q, act_lat_d;
    logic        act_sel_q, act_sel_d;
    logic [9:0]  eps_q, eps_d;
    logic [7:0]  step_q, step_d, decay_q, decay_d;
    logic [15:0] ep_q, ep_d;

    logic [7:0]  step_inc, decay_inc;
    logic [15:0] ep_inc;

    // Epsilon decrement that clamps at zero instead of wrapping.
    function automatic logic [9:0] eps_sat_dec(input logic [9:0] e);
        return (e > EPS_STEP) ? (e - EPS_STEP) : 10'd0;
    endfunction

    assign step_inc  = step_q + 8'd1;
    assign decay_inc = decay_q + 8'd1;
    assign ep_inc    = ep_q + 16'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            curr_q    <= '0;
            prev_q    <= '0;
            nxt_q     <= '0;
            act_lat_q <= '0;
            act_sel_q <= 1'b0;
            eps_q     <= EPS_INIT;
            step_q    <= '0;
            decay_q   <= '0;
            ep_q      <= '0;
        end else begin
            state_q   <= state_d;
            curr_q    <= curr_d;
            prev_q    <= prev_d;
            nxt_q     <= nxt_d;
            act_lat_q <= act_lat_d;
            act_sel_q <= act_sel_d;
            eps_q     <= eps_d;
            step_q    <= step_d;
            decay_q   <= decay_d;
            ep_q      <= ep_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        curr_d    = curr_q;
        prev_d    = prev_q;
        nxt_d     = nxt_q;
        act_lat_d = act_lat_q;
        act_sel_d = act_sel_q;
        eps_d     = eps_q;
        step_d    = step_q;
        decay_d   = decay_q;
        ep_d      = ep_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    curr_d  = '0;
                    prev_d  = '0;
                    step_d  = '0;
                    ep_d    = '0;
                    decay_d = '0;
                    eps_d   = EPS_INIT;
                end
            end
            S_FETCH: begin
                act_sel_d = (rand_val < eps_q);
                state_d   = S_DECIDE;
            end
            S_DECIDE: begin
                act_lat_d = nxt_act_in;
                state_d   = S_MOVE;
            end
            S_MOVE: begin
                nxt_d   = nxt_state_in;
                state_d = S_WRITE;
            end
            S_WRITE: state_d = S_ADVANCE;
            S_ADVANCE: begin
                prev_d  = curr_q;
                curr_d  = nxt_q;
                step_d  = step_inc;
                state_d = ((nxt_q == GOAL_STATE) || (step_inc == MAX_STEPS)) ? S_EPEND : S_FETCH;
            end
            S_EPEND: begin
                curr_d = '0;
                prev_d = '0;
                step_d = '0;
                ep_d   = ep_inc;
                if (decay_inc == EPS_DECAY_EP) begin
                    decay_d = '0;
                    eps_d   = eps_sat_dec(eps_q);
                end else begin
                    decay_d = decay_inc;
                end
                state_d = (ep_inc == MAX_EPISODES) ? S_DONE : S_FETCH;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes decode the registered state so an async reset removes them at once.
    assign q_wr_en     = (state_q == S_WRITE);
    assign state_rst   = (state_q == S_EPEND);
    assign done        = (state_q == S_DONE);
    assign busy        = (state_q != S_IDLE);
    assign curr_state  = curr_q;
    assign prev_state  = prev_q;
    assign act_q       = act_lat_q;
    assign act_sel     = act_sel_q;
    assign epsilon     = eps_q;
    assign step_cnt    = step_q;
    assign episode_cnt = ep_q;

endmodule

// File: tb/tb_qlearn_step_ctrl.sv
// Directed bench for qlearn_step_ctrl: default-parameter unit for step/explore/goal/reset,
// a small-limit unit for step-limit termination, epsilon decay and completion.
module tb_qlearn_step_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic [9:0]  rand_val = '0;
    logic [1:0]  nxt_act = '0;
    logic [7:0]  nxt_state_a = '0;

    logic [7:0]  curr_a, prev_a, step_a, curr_b, prev_b, step_b;
    logic [1:0]  actq_a, actq_b;
    logic        sel_a, wr_a, srst_a, busy_a, done_a;
    logic        sel_b, wr_b, srst_b, busy_b, done_b;
    logic [9:0]  eps_a, eps_b;
    logic [15:0] ep_a, ep_b;

    int checks = 0;
    int errors = 0;
    int n;
    int eps_exp [1:5] = '{512, 212, 212, 0, 0};

    always #5 clk = ~clk;

    qlearn_step_ctrl dut_a (
        .clk(clk), .rst(rst), .start(start_a), .rand_val(rand_val),
        .nxt_act_in(nxt_act), .nxt_state_in(nxt_state_a),
        .curr_state(curr_a), .prev_state(prev_a), .act_q(actq_a), .act_sel(sel_a),
        .q_wr_en(wr_a), .state_rst(srst_a), .epsilon(eps_a), .step_cnt(step_a),
        .episode_cnt(ep_a), .busy(busy_a), .done(done_a)
    );

    qlearn_step_ctrl #(
        .MAX_STEPS(8'd4), .MAX_EPISODES(16'd5), .EPS_STEP(10'd300), .EPS_DECAY_EP(8'd2)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .rand_val(rand_val),
        .nxt_act_in(nxt_act), .nxt_state_in(curr_b),
        .curr_state(curr_b), .prev_state(prev_b), .act_q(actq_b), .act_sel(sel_b),
        .q_wr_en(wr_b), .state_rst(srst_b), .epsilon(eps_b), .step_cnt(step_b),
        .episode_cnt(ep_b), .busy(busy_b), .done(done_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_b_epend(output int cnt);
        cnt = 0;
        while (srst_b !== 1'b1 && cnt < 100) begin
            tick();
            cnt++;
        end
    endtask

    initial begin
        // Reset values
        tick();
        chk("rst_curr", curr_a, 0);
        chk("rst_prev", prev_a, 0);
        chk("rst_actq", actq_a, 0);
        chk("rst_actsel", sel_a, 0);
        chk("rst_wr", wr_a, 0);
        chk("rst_srst", srst_a, 0);
        chk("rst_eps", eps_a, 512);
        chk("rst_step", step_a, 0);
        chk("rst_ep", ep_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        rst = 1'b0;
        tick(); tick(); tick();
        chk("idle_busy", busy_a, 0);

        // Single step, greedy (600 >= 512)
        rand_val = 10'd600; nxt_act = 2'd0; nxt_state_a = 8'd1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("s1_busy", busy_a, 1);
        chk("s1_wr_c1", wr_a, 0);
        tick();
        chk("s1_actsel", sel_a, 0);
        chk("s1_wr_c2", wr_a, 0);
        tick();
        chk("s1_actq", actq_a, 0);
        chk("s1_wr_c3", wr_a, 0);
        tick();
        chk("s1_wr_c4", wr_a, 1);
        chk("s1_wr_curr", curr_a, 0);
        chk("s1_wr_actq", actq_a, 0);
        tick();
        chk("s1_wr_c5", wr_a, 0);
        chk("s1_adv_curr", curr_a, 0);
        tick();
        chk("s1_curr", curr_a, 1);
        chk("s1_prev", prev_a, 0);
        chk("s1_step", step_a, 1);

        // Explore step: 100 < 512
        rand_val = 10'd100; nxt_act = 2'd2; nxt_state_a = 8'd2;
        tick();
        chk("s2_actsel", sel_a, 1);
        tick();
        chk("s2_actq", actq_a, 2);
        tick();
        chk("s2_wr", wr_a, 1);
        chk("s2_wr_curr", curr_a, 1);
        chk("s2_wr_actq", actq_a, 2);
        tick(); tick();
        chk("s2_curr", curr_a, 2);
        chk("s2_prev", prev_a, 1);
        chk("s2_step", step_a, 2);

        // Step 3 reaches the goal; 512 is not below 512
        rand_val = 10'd512; nxt_act = 2'd1; nxt_state_a = 8'd99;
        tick();
        chk("s3_actsel", sel_a, 0);
        tick(); tick(); tick(); tick();
        chk("goal_srst", srst_a, 1);
        chk("goal_wr", wr_a, 0);
        chk("goal_curr99", curr_a, 99);
        chk("goal_step3", step_a, 3);
        tick();
        chk("goal_srst_off", srst_a, 0);
        chk("goal_curr", curr_a, 0);
        chk("goal_prev", prev_a, 0);
        chk("goal_step", step_a, 0);
        chk("goal_ep", ep_a, 1);
        chk("goal_busy", busy_a, 1);
        chk("goal_eps", eps_a, 512);

        // Reset asserted during WRITE
        nxt_state_a = 8'd5;
        tick(); tick(); tick();
        chk("mw_wr_before", wr_a, 1);
        rst = 1'b1;
        #1;
        chk("mw_wr", wr_a, 0);
        chk("mw_busy", busy_a, 0);
        chk("mw_ep", ep_a, 0);
        chk("mw_eps", eps_a, 512);
        tick();
        rst = 1'b0;
        tick(); tick();
        chk("mw_post_busy", busy_a, 0);
        chk("mw_post_wr", wr_a, 0);
        chk("mw_post_curr", curr_a, 0);
        chk("mw_post_step", step_a, 0);

        // Step-limit episodes with decay, then completion
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("b_busy", busy_b, 1);
        for (int k = 1; k <= 5; k++) begin
            wait_b_epend(n);
            chk($sformatf("b_ep%0d_len", k), n, 20);
            chk($sformatf("b_ep%0d_step", k), step_b, 4);
            chk($sformatf("b_ep%0d_epbefore", k), ep_b, k - 1);
            tick();
            chk($sformatf("b_ep%0d_cnt", k), ep_b, k);
            chk($sformatf("b_ep%0d_step0", k), step_b, 0);
            chk($sformatf("b_ep%0d_eps", k), eps_b, eps_exp[k]);
            chk($sformatf("b_ep%0d_srst_off", k), srst_b, 0);
        end
        chk("b_done", done_b, 1);
        chk("b_done_busy", busy_b, 1);
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("b_done_off", done_b, 0);
        chk("b_busy_off", busy_b, 0);
        tick();
        chk("b_start_ignored", busy_b, 0);
        chk("b_ep_held", ep_b, 5);
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("b_restart_busy", busy_b, 1);
        chk("b_restart_ep", ep_b, 0);
        chk("b_restart_eps", eps_b, 512);
        chk("b_restart_step", step_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
